// File: rtl/card_dealer_if.sv
// Deck handshake between the card dealer (master) and the shuffling deck (slave).
// top_card is combinational from the deck and is only meaningful while deck_ready is high.
interface card_dealer_if #(
    parameter int CARD_W = 6
);
    logic [CARD_W-1:0] top_card;
    logic              deck_ready;
    logic              start_shuffle;
    logic              draw_card;

    modport master (
        input  top_card,
        input  deck_ready,
        output start_shuffle,
        output draw_card
    );

    modport slave (
        output top_card,
        output deck_ready,
        input  start_shuffle,
        input  draw_card
    );
endinterface

// File: rtl/card_dealer.sv
// Hold'em dealer: requests a shuffle, deals two hole cards per player round-robin,
// then burns one card and deals flop/turn/river on each street command.
module card_dealer #(
    parameter int NUM_PLAYERS = 4,
    parameter int CARD_W      = 6
) (
    input  logic                                   clk_i,
    input  logic                                   reset_ni,
    input  logic                                   start_hand_i,
    input  logic                                   next_street_i,
    card_dealer_if.master                          deck,
    output logic [NUM_PLAYERS-1:0][1:0][CARD_W-1:0] hole_cards_o,
    output logic                                   hole_valid_o,
    output logic [4:0][CARD_W-1:0]                 community_o,
    output logic [2:0]                             community_count_o,
    output logic [1:0]                             street_o,
    output logic                                   busy_o,
    output logic [5:0]                             cards_used_o
);

    localparam int       PW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [3:0] N4     = 4'(NUM_PLAYERS);
    localparam logic [3:0] LAST_K = 4'(2 * NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHUF_REQ,
        SHUF_WAIT,
        DEAL_HOLE,
        WAIT_STREET,
        BURN,
        DEAL_COMM,
        HAND_DONE
    } state_t;

    state_t                                 state_q, state_d;
    logic [NUM_PLAYERS-1:0][1:0][CARD_W-1:0] hole_q, hole_d;
    logic [4:0][CARD_W-1:0]                 comm_q, comm_d;
    logic [2:0]                             cnt_q, cnt_d;
    logic [1:0]                             street_q, street_d;
    logic                                   hv_q, hv_d;
    logic [5:0]                             used_q, used_d;
    logic [3:0]                             k_q, k_d;

    logic          draw;
    logic          card_sel;
    logic [PW-1:0] player;

    // Draw states freeze whenever the deck drops ready, so draw_card is gated by it.
    assign draw = deck.deck_ready &&
                  ((state_q == DEAL_HOLE) || (state_q == BURN) || (state_q == DEAL_COMM));

    // Round-robin: first N draws are card 0 of each player, next N are card 1.
    assign card_sel = (k_q >= N4);
    assign player   = PW'(card_sel ? (k_q - N4) : k_q);

    always_comb begin
        state_d  = state_q;
        hole_d   = hole_q;
        comm_d   = comm_q;
        cnt_d    = cnt_q;
        street_d = street_q;
        hv_d     = hv_q;
        used_d   = used_q;
        k_d      = k_q;

        if (draw) begin
            used_d = used_q + 6'd1;
        end

        case (state_q)
            IDLE, WAIT_STREET, HAND_DONE: begin
                if (start_hand_i) begin
                    state_d  = SHUF_REQ;
                    hole_d   = '0;
                    comm_d   = '0;
                    cnt_d    = '0;
                    street_d = '0;
                    hv_d     = 1'b0;
                    used_d   = '0;
                    k_d      = '0;
                end else if ((state_q == WAIT_STREET) && next_street_i) begin
                    state_d = BURN;
                end
            end
            SHUF_REQ: begin
                state_d = SHUF_WAIT;
            end
            SHUF_WAIT: begin
                if (deck.deck_ready) begin
                    state_d = DEAL_HOLE;
                end
            end
            DEAL_HOLE: begin
                if (draw) begin
                    hole_d[player][card_sel] = deck.top_card;
                    k_d = k_q + 4'd1;
                    if (k_q == LAST_K) begin
                        hv_d     = 1'b1;
                        street_d = 2'd0;
                        state_d  = WAIT_STREET;
                    end
                end
            end
            BURN: begin
                if (draw) begin
                    state_d = DEAL_COMM;
                end
            end
            DEAL_COMM: begin
                if (draw) begin
                    comm_d[cnt_q] = deck.top_card;
                    cnt_d = cnt_q + 3'd1;
                    // Flop ends on its third card; turn and river are single cards.
                    if ((street_q != 2'd0) || (cnt_q == 3'd2)) begin
                        street_d = street_q + 2'd1;
                        state_d  = (street_q == 2'd2) ? HAND_DONE : WAIT_STREET;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            hole_q   <= '0;
            comm_q   <= '0;
            cnt_q    <= '0;
            street_q <= '0;
            hv_q     <= 1'b0;
            used_q   <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            hole_q   <= hole_d;
            comm_q   <= comm_d;
            cnt_q    <= cnt_d;
            street_q <= street_d;
            hv_q     <= hv_d;
            used_q   <= used_d;
            k_q      <= k_d;
        end
    end

    assign deck.start_shuffle = (state_q == SHUF_REQ);
    assign deck.draw_card     = draw;

    assign hole_cards_o      = hole_q;
    assign hole_valid_o      = hv_q;
    assign community_o       = comm_q;
    assign community_count_o = cnt_q;
    assign street_o          = street_q;
    assign busy_o            = !((state_q == IDLE) || (state_q == WAIT_STREET) ||
                                 (state_q == HAND_DONE));
    assign cards_used_o      = used_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: two dealers (4 and 8 players), each fed by a simple
// deck model whose i-th card after a shuffle has the value i+8.
module tb_card_dealer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic sh4 = 1'b0, ns4 = 1'b0, sh8 = 1'b0, ns8 = 1'b0;

    card_dealer_if #(.CARD_W(6)) d4 ();
    card_dealer_if #(.CARD_W(6)) d8 ();

    logic [3:0][1:0][5:0] hole4;
    logic [7:0][1:0][5:0] hole8;
    logic [4:0][5:0]      comm4, comm8;
    logic                 hv4, hv8, busy4, busy8;
    logic [2:0]           cc4, cc8;
    logic [1:0]           st4, st8;
    logic [5:0]           used4, used8;

    card_dealer #(.NUM_PLAYERS(4), .CARD_W(6)) u4 (
        .clk_i(clk), .reset_ni(rst_n), .start_hand_i(sh4), .next_street_i(ns4),
        .deck(d4), .hole_cards_o(hole4), .hole_valid_o(hv4), .community_o(comm4),
        .community_count_o(cc4), .street_o(st4), .busy_o(busy4), .cards_used_o(used4)
    );

    card_dealer #(.NUM_PLAYERS(8), .CARD_W(6)) u8 (
        .clk_i(clk), .reset_ni(rst_n), .start_hand_i(sh8), .next_street_i(ns8),
        .deck(d8), .hole_cards_o(hole8), .hole_valid_o(hv8), .community_o(comm8),
        .community_count_o(cc8), .street_o(st8), .busy_o(busy8), .cards_used_o(used8)
    );

    // Deck models: a shuffle drops ready for shuf_len edges, then cards stream in order.
    int   shuf_len = 4;
    int   idx4 = 0, cd4 = 0, idx8 = 0, cd8 = 0;
    logic rdy4 = 1'b0, rdy8 = 1'b0, stall4 = 1'b0;

    always @(posedge clk) begin
        if (d4.start_shuffle) begin
            rdy4 <= 1'b0; cd4 <= shuf_len; idx4 <= 0;
        end else if (cd4 > 0) begin
            cd4 <= cd4 - 1;
            if (cd4 == 1) rdy4 <= 1'b1;
        end else if (d4.draw_card) begin
            idx4 <= idx4 + 1;
        end
    end

    always @(posedge clk) begin
        if (d8.start_shuffle) begin
            rdy8 <= 1'b0; cd8 <= shuf_len; idx8 <= 0;
        end else if (cd8 > 0) begin
            cd8 <= cd8 - 1;
            if (cd8 == 1) rdy8 <= 1'b1;
        end else if (d8.draw_card) begin
            idx8 <= idx8 + 1;
        end
    end

    assign d4.deck_ready = rdy4 & ~stall4;
    assign d4.top_card   = 6'(idx4 + 8);
    assign d8.deck_ready = rdy8;
    assign d8.top_card   = 6'(idx8 + 8);

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [5:0] c(input int i);
        return 6'(i + 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4();
        sh4 = 1'b1;
        tick();
        sh4 = 1'b0;
    endtask

    task automatic wait_hole(input bit big);
        int cyc = 0;
        bit ovl = 1'b0;
        while (!(big ? hv8 : hv4) && cyc < 300) begin
            if (big ? (d8.draw_card && d8.start_shuffle) : (d4.draw_card && d4.start_shuffle))
                ovl = 1'b1;
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL hole_timeout: hole_valid=0 after %0d cycles, required 1", cyc);
        end
        n_tests++;
        if (ovl !== 1'b0) begin
            n_fail++;
            $display("FAIL draw_vs_shuffle: both high in one cycle=%0b, required 0", ovl);
        end
    endtask

    task automatic street(input bit big, input int k, input logic [2:0] ecc, input logic [1:0] est);
        if (big) ns8 = 1'b1; else ns4 = 1'b1;
        tick();
        ns4 = 1'b0;
        ns8 = 1'b0;
        n_tests++;
        if ((big ? d8.draw_card : d4.draw_card) !== 1'b1 || (big ? busy8 : busy4) !== 1'b1) begin
            n_fail++;
            $display("FAIL burn_cycle: draw=%0b busy=%0b, required 1 1",
                     big ? d8.draw_card : d4.draw_card, big ? busy8 : busy4);
        end
        repeat (k + 1) tick();
        n_tests++;
        if ((big ? cc8 : cc4) !== ecc) begin
            n_fail++;
            $display("FAIL street_count: community_count=%0d, required %0d", big ? cc8 : cc4, ecc);
        end
        n_tests++;
        if ((big ? st8 : st4) !== est || (big ? busy8 : busy4) !== 1'b0) begin
            n_fail++;
            $display("FAIL street_state: street=%0d busy=%0b, required %0d 0",
                     big ? st8 : st4, big ? busy8 : busy4, est);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_tests++;
        if ({busy4, hv4, cc4, st4, used4, d4.start_shuffle, d4.draw_card, hole4, comm4} !== '0) begin
            n_fail++;
            $display("FAIL reset_n4: busy=%0b hv=%0b cc=%0d st=%0d used=%0d, required all 0",
                     busy4, hv4, cc4, st4, used4);
        end
        n_tests++;
        if ({busy8, hv8, cc8, st8, used8, d8.start_shuffle, d8.draw_card, hole8, comm8} !== '0) begin
            n_fail++;
            $display("FAIL reset_n8: busy=%0b hv=%0b cc=%0d st=%0d used=%0d, required all 0",
                     busy8, hv8, cc8, st8, used8);
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_full_hand();
        start4();
        n_tests++;
        if (d4.start_shuffle !== 1'b1 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL shuffle_req: start_shuffle=%0b busy=%0b, required 1 1", d4.start_shuffle, busy4);
        end
        tick();
        n_tests++;
        if (d4.start_shuffle !== 1'b0) begin
            n_fail++;
            $display("FAIL shuffle_pulse: start_shuffle=%0b in 2nd cycle, required 0", d4.start_shuffle);
        end
        wait_hole(1'b0);
        for (int p = 0; p < 4; p++) begin
            n_tests++;
            if (hole4[p][0] !== c(p) || hole4[p][1] !== c(4 + p)) begin
                n_fail++;
                $display("FAIL hole_p%0d: got %0d/%0d, required %0d/%0d",
                         p, hole4[p][0], hole4[p][1], c(p), c(4 + p));
            end
        end
        n_tests++;
        if (used4 !== 6'd8 || st4 !== 2'd0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL after_hole: used=%0d st=%0d busy=%0b, required 8 0 0", used4, st4, busy4);
        end
        street(1'b0, 3, 3'd3, 2'd1);
        n_tests++;
        if (comm4[0] !== c(9) || comm4[1] !== c(10) || comm4[2] !== c(11)) begin
            n_fail++;
            $display("FAIL flop: got %0d %0d %0d, required %0d %0d %0d",
                     comm4[0], comm4[1], comm4[2], c(9), c(10), c(11));
        end
        street(1'b0, 1, 3'd4, 2'd2);
        n_tests++;
        if (comm4[3] !== c(13)) begin
            n_fail++;
            $display("FAIL turn: got %0d, required %0d", comm4[3], c(13));
        end
        street(1'b0, 1, 3'd5, 2'd3);
        n_tests++;
        if (comm4[4] !== c(15) || used4 !== 6'd16) begin
            n_fail++;
            $display("FAIL river: got %0d used=%0d, required %0d 16", comm4[4], used4, c(15));
        end
        // next_street in HAND_DONE must do nothing
        ns4 = 1'b1;
        tick();
        ns4 = 1'b0;
        n_tests++;
        if (d4.draw_card !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ignore_draw: draw=%0b busy=%0b, required 0 0", d4.draw_card, busy4);
        end
        tick(); tick();
        n_tests++;
        if (cc4 !== 3'd5 || used4 !== 6'd16) begin
            n_fail++;
            $display("FAIL done_ignore_count: cc=%0d used=%0d, required 5 16", cc4, used4);
        end
        $display("[TB] full hand N=4 checked");
    endtask

    task automatic test_ignore_during_deal();
        int cyc = 0;
        start4();
        while (d4.draw_card !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        ns4 = 1'b1;
        tick();
        ns4 = 1'b0;
        wait_hole(1'b0);
        repeat (4) tick();
        n_tests++;
        if (cc4 !== 3'd0 || st4 !== 2'd0 || used4 !== 6'd8 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL deal_ignore: cc=%0d st=%0d used=%0d busy=%0b, required 0 0 8 0",
                     cc4, st4, used4, busy4);
        end
        $display("[TB] next_street during deal checked");
    endtask

    task automatic test_freeze();
        int cyc = 0;
        logic [5:0] u;
        bit drew = 1'b0;
        start4();
        while (d4.draw_card !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        tick(); tick();
        stall4 = 1'b1;
        #1;
        u = used4;
        repeat (3) begin
            if (d4.draw_card !== 1'b0) drew = 1'b1;
            tick();
        end
        n_tests++;
        if (drew !== 1'b0 || used4 !== u) begin
            n_fail++;
            $display("FAIL freeze: drew=%0b used=%0d, required 0 %0d", drew, used4, u);
        end
        stall4 = 1'b0;
        #1;
        n_tests++;
        if (d4.draw_card !== 1'b1) begin
            n_fail++;
            $display("FAIL resume: draw=%0b, required 1", d4.draw_card);
        end
        wait_hole(1'b0);
        n_tests++;
        if (hole4[3][1] !== c(7) || hole4[1][0] !== c(1) || used4 !== 6'd8) begin
            n_fail++;
            $display("FAIL freeze_hole: h31=%0d h10=%0d used=%0d, required %0d %0d 8",
                     hole4[3][1], hole4[1][0], used4, c(7), c(1));
        end
        $display("[TB] ready drop during deal checked");
    endtask

    task automatic test_same_cycle();
        street(1'b0, 3, 3'd3, 2'd1);
        sh4 = 1'b1;
        ns4 = 1'b1;
        tick();
        sh4 = 1'b0;
        ns4 = 1'b0;
        n_tests++;
        if (d4.start_shuffle !== 1'b1 || cc4 !== 3'd0 || hv4 !== 1'b0 || busy4 !== 1'b1 || d4.draw_card !== 1'b0) begin
            n_fail++;
            $display("FAIL start_wins: shuf=%0b cc=%0d hv=%0b busy=%0b draw=%0b, required 1 0 0 1 0",
                     d4.start_shuffle, cc4, hv4, busy4, d4.draw_card);
        end
        wait_hole(1'b0);
        $display("[TB] start_hand beats next_street checked");
    endtask

    task automatic test_ready_low();
        int cyc = 0;
        bit drew = 1'b0;
        shuf_len = 10;
        start4();
        tick();
        while (d4.deck_ready !== 1'b1 && cyc < 50) begin
            if (d4.draw_card !== 1'b0) drew = 1'b1;
            tick();
            cyc++;
        end
        n_tests++;
        if (drew !== 1'b0 || d4.draw_card !== 1'b0 || cyc < 9) begin
            n_fail++;
            $display("FAIL ready_low: drew=%0b draw_now=%0b low_cycles=%0d, required 0 0 >=9",
                     drew, d4.draw_card, cyc);
        end
        tick();
        n_tests++;
        if (d4.draw_card !== 1'b1) begin
            n_fail++;
            $display("FAIL deal_start: draw=%0b one cycle after ready, required 1", d4.draw_card);
        end
        wait_hole(1'b0);
        shuf_len = 4;
        $display("[TB] slow shuffle checked");
    endtask

    task automatic test_reset_mid();
        ns4 = 1'b1;
        tick();
        ns4 = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (d4.draw_card !== 1'b1 || cc4 !== 3'd2) begin
            n_fail++;
            $display("FAIL third_flop: draw=%0b cc=%0d, required 1 2", d4.draw_card, cc4);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy4 !== 1'b0 || cc4 !== 3'd0 || d4.draw_card !== 1'b0 || hv4 !== 1'b0 || used4 !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%0b cc=%0d draw=%0b hv=%0b used=%0d, required 0 0 0 0 0",
                     busy4, cc4, d4.draw_card, hv4, used4);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start4();
        wait_hole(1'b0);
        n_tests++;
        if (hole4[0][0] !== c(0) || hole4[2][1] !== c(6) || used4 !== 6'd8) begin
            n_fail++;
            $display("FAIL after_reset: h00=%0d h21=%0d used=%0d, required %0d %0d 8",
                     hole4[0][0], hole4[2][1], used4, c(0), c(6));
        end
        $display("[TB] reset mid-flop checked");
    endtask

    task automatic test_n8();
        sh8 = 1'b1;
        tick();
        sh8 = 1'b0;
        wait_hole(1'b1);
        n_tests++;
        if (hole8[7][1] !== c(15) || hole8[0][0] !== c(0) || hole8[3][1] !== c(11)) begin
            n_fail++;
            $display("FAIL n8_hole: h71=%0d h00=%0d h31=%0d, required %0d %0d %0d",
                     hole8[7][1], hole8[0][0], hole8[3][1], c(15), c(0), c(11));
        end
        street(1'b1, 3, 3'd3, 2'd1);
        street(1'b1, 1, 3'd4, 2'd2);
        street(1'b1, 1, 3'd5, 2'd3);
        n_tests++;
        if (comm8[4] !== c(23) || comm8[0] !== c(17) || used8 !== 6'd24) begin
            n_fail++;
            $display("FAIL n8_board: river=%0d flop0=%0d used=%0d, required %0d %0d 24",
                     comm8[4], comm8[0], used8, c(23), c(17));
        end
        $display("[TB] full hand N=8 checked");
    endtask

    initial begin
        test_reset();
        test_full_hand();
        test_ignore_during_deal();
        test_freeze();
        test_same_cycle();
        test_ready_low();
        test_reset_mid();
        test_n8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Downstream consumer of the shuffling card deck. On a hand-start command it requests a shuffle, waits for the deck to report ready, then draws two hole cards per player. On each later street command it burns one card and deals the flop (3), turn (1) or river (1) into the community registers. Its outputs feed the betting and hand-evaluation logic.

## Interface
- NUM_PLAYERS, default 4, number of seated players (legal range 2..8).
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset; all state and outputs are cleared while it is 0.
- start_hand  in  1  single-cycle pulse that begins a new hand.
- next_street  in  1  single-cycle pulse that deals the next community street.
- top_card  in  card_t  current top card from the deck; combinational, valid while deck_ready=1.
- deck_ready  in  1  the deck is shuffled and may be drawn from.
- start_shuffle  out  1  one-cycle shuffle request to the deck.
- draw_card  out  1  consumes top_card this cycle; the deck advances on the same edge.
- hole_cards  out  card_t [NUM_PLAYERS][2]  hole cards, indexed [player][card].
- hole_valid  out  1  all hole cards have been dealt.
- community  out  card_t [5]  board cards, slots 0..4.
- community_count  out  3  number of valid community slots: 0, 3, 4 or 5.
- street  out  2  0 = preflop, 1 = flop, 2 = turn, 3 = river.
- busy  out  1  high in every state except IDLE, WAIT_STREET and HAND_DONE.
- cards_used  out  6  cards drawn this hand, burns included.

## Operation
- States: IDLE, SHUF_REQ, SHUF_WAIT, DEAL_HOLE, WAIT_STREET, BURN, DEAL_COMM, HAND_DONE.
- IDLE: all outputs are 0.
- start_hand is accepted only when busy=0. On acceptance, in any non-busy state:
  - clear the hole cards, community cards, counters and hole_valid;
  - go to SHUF_REQ.
- SHUF_REQ: assert start_shuffle for exactly 1 cycle, then go to SHUF_WAIT.
- SHUF_WAIT: wait for deck_ready=1, then go to DEAL_HOLE. The deck's ready is already low in the cycle after the request, so a stale ready cannot be sampled.
- DEAL_HOLE: assert draw_card every cycle for 2·NUM_PLAYERS cycles.
  - Draw index k stores top_card into hole_cards[k mod N][k / N]. Round-robin: card 0 to players 0..N-1, then card 1.
  - After the last draw: hole_valid=1, street=0, go to WAIT_STREET.
- WAIT_STREET: on next_street, go to BURN.
- BURN: assert draw_card for 1 cycle; the card is discarded.
- DEAL_COMM: assert draw_card for 3 cycles on the flop and 1 cycle on turn and river.
  - Store into community[community_count], then increment the count.
  - Increment street on the last draw.
  - If the street just completed was the river (3), go to HAND_DONE; otherwise go to WAIT_STREET.
- HAND_DONE: next_street is ignored. start_hand begins a new hand.
- next_street is ignored in every state except WAIT_STREET.
- start_hand while busy=1 is ignored.
- start_hand and next_street in the same cycle (non-busy): start_hand wins.
- cards_used increments on every draw_card cycle. Maximum is 2·8+3+5 = 24, so no wrap is possible within 6 bits.
- If deck_ready falls during a draw state, the draw state freezes: no draw_card, no counters advance. It resumes when deck_ready returns to 1.
- Reset asserted mid-operation: immediately returns to IDLE with all outputs 0, including start_shuffle and draw_card.

## Timing
- start_hand sampled at edge E → start_shuffle is high during cycle E+1.
- deck_ready first sampled high at edge R:
  - draw_card is high from R+1 through R+2N.
  - hole_valid and busy=0 take effect after edge R+2N+1.
- Hole card latency with the reference deck (52-cycle shuffle) and N=4: about 63 cycles from start_hand.
- next_street sampled at edge S:
  - burn draw in cycle S+1;
  - deal draws in S+2 .. S+1+k (k = 3 or 1);
  - community_count, street and busy=0 are updated by edge S+2+k.
- Card capture: top_card is registered on the same edge that draw_card is high.
- draw_card and start_shuffle are never high in the same cycle.

## Test plan
- Full hand, N=4, deck model emits c0, c1, c2, … → hole[p][0]=c[p], hole[p][1]=c[4+p]; flop = c9..c11 (c8 burned); turn = c13; river = c15; cards_used=16; street=3; then HAND_DONE.
- N=8 full hand → hole[7][1]=c15; river=c23; cards_used=24.
- next_street pulsed during DEAL_HOLE, and again in HAND_DONE → ignored in both cases; community_count is unchanged.
- start_hand and next_street in the same cycle in WAIT_STREET with count=3 → new shuffle starts; community_count=0; hole_valid=0.
- deck_ready held low for 10 cycles after the request → no draw_card during that time; dealing starts 1 cycle after ready rises.
- reset dropped during the 3rd flop draw → busy=0, community_count=0, draw_card=0 immediately; the next start_hand deals correctly.
